// File: rtl/yarp_pkg.sv
// Shared encodings for the vector datapath.
package yarp_pkg;

  localparam logic V_ADD  = 1'b0;
  localparam logic V_MMUL = 1'b1;

endpackage

// File: rtl/valu_seq.sv
// Sequencer that runs one vector ALU command: fetch A/B rows, execute, write back, pulse done.
// All outputs are registered and decoded from the next state so they line up with the state they belong to.
module valu_seq #(
  parameter int unsigned ELEM_WIDTH = 32,
  parameter int unsigned VEC_COUNT  = 4,
  parameter int unsigned VREG_COUNT = 32,
  localparam int unsigned AW = $clog2(VREG_COUNT),
  localparam int unsigned RW = ELEM_WIDTH * VEC_COUNT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_src_a,
  input  logic [AW-1:0] cmd_src_b,
  input  logic [AW-1:0] cmd_dst,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [RW-1:0] rf_rd_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [RW-1:0] rf_wr_data,
  output logic          valu_op,
  output logic [RW-1:0] valu_a   [VEC_COUNT],
  output logic [RW-1:0] valu_b   [VEC_COUNT],
  input  logic [RW-1:0] valu_res [VEC_COUNT],
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = $clog2(2 * VEC_COUNT + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(2 * VEC_COUNT);
  localparam logic [CW-1:0] WB_LAST   = CW'(VEC_COUNT - 1);
  localparam logic [CW-1:0] VC        = CW'(VEC_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [AW-1:0] src_a_q, src_a_d;
  logic [AW-1:0] src_b_q, src_b_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [RW-1:0] a_q   [VEC_COUNT];
  logic [RW-1:0] a_d   [VEC_COUNT];
  logic [RW-1:0] b_q   [VEC_COUNT];
  logic [RW-1:0] b_d   [VEC_COUNT];
  logic [RW-1:0] res_q [VEC_COUNT];
  logic [RW-1:0] res_d [VEC_COUNT];

  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [RW-1:0] wr_data_q, wr_data_d;

  // Next-state, datapath capture and next-cycle output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cmd_ready_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          op_d    = cmd_op;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          dst_d   = cmd_dst;
        end
      end
      S_LOAD: begin
        // Read data lags the strobe by one cycle, so count value n fills slot n-1
        for (int i = 0; i < int'(VEC_COUNT); i++) begin
          if (cnt_q == CW'(i + 1))               a_d[i] = rf_rd_data;
          if (cnt_q == CW'(int'(VEC_COUNT) + i + 1)) b_d[i] = rf_rd_data;
        end
        if (cnt_q == LOAD_LAST) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        res_d   = valu_res;
        state_d = S_WB;
        cnt_d   = '0;
      end
      S_WB: begin
        if (cnt_q == WB_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_LOAD) && (cnt_d < LOAD_LAST);
    if (rd_en_d) begin
      rd_addr_d = (cnt_d < VC) ? src_a_d + AW'(cnt_d) : src_b_d + AW'(cnt_d - VC);
    end
    wr_en_d = (state_d == S_WB);
    if (wr_en_d) begin
      wr_addr_d = dst_d + AW'(cnt_d);
      for (int i = 0; i < int'(VEC_COUNT); i++) begin
        if (cnt_d == CW'(i)) wr_data_d = res_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= yarp_pkg::V_ADD;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      for (int i = 0; i < int'(VEC_COUNT); i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_rd_en   = rd_en_q;
  assign rf_rd_addr = rd_addr_q;
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign valu_op    = op_q;
  assign valu_a     = a_q;
  assign valu_b     = b_q;

endmodule

// File: tb/tb_valu_seq.sv
// Bench for valu_seq: register file and ALU stand-ins, directed table, random commands, handshake and reset corners.
module tb_valu_seq;
  import yarp_pkg::*;

  localparam int EW = 32;
  localparam int V  = 4;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int RW = EW * V;
  localparam int HN = 16384;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [AW-1:0] cmd_src_a = '0;
  logic [AW-1:0] cmd_src_b = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic          rf_rd_en;
  logic [AW-1:0] rf_rd_addr;
  logic [RW-1:0] rf_rd_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [RW-1:0] rf_wr_data;
  logic          valu_op;
  logic [RW-1:0] valu_a   [V];
  logic [RW-1:0] valu_b   [V];
  logic [RW-1:0] valu_res [V];
  logic          busy;
  logic          done;

  valu_seq #(.ELEM_WIDTH(EW), .VEC_COUNT(V), .VREG_COUNT(NR)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .valu_op(valu_op), .valu_a(valu_a), .valu_b(valu_b), .valu_res(valu_res),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency, DUT write wins over bench preload
  logic [RW-1:0] mem [NR];
  logic          tb_we = 1'b0;
  int            tb_addr = 0;
  logic [RW-1:0] tb_data = '0;
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
    if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    else if (tb_we) mem[tb_addr[AW-1:0]] <= tb_data;
  end

  // ALU stand-in: element-wise add or row-major matrix multiply
  always_comb begin
    for (int i = 0; i < V; i++) begin
      valu_res[i] = '0;
      for (int j = 0; j < V; j++) begin
        if (valu_op == V_ADD)
          valu_res[i][j*EW +: EW] = valu_a[i][j*EW +: EW] + valu_b[i][j*EW +: EW];
        else
          for (int k = 0; k < V; k++)
            valu_res[i][j*EW +: EW] = valu_res[i][j*EW +: EW] + valu_a[i][k*EW +: EW] * valu_b[k][j*EW +: EW];
      end
    end
  end

  typedef struct { int cyc; int addr; logic [RW-1:0] data; } ev_t;
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  int   done_q[$];
  int   clash = 0;
  logic busy_h [HN];
  logic rdy_h  [HN];

  always @(negedge clk) begin
    if (cyc < HN) begin
      busy_h[cyc] = busy;
      rdy_h[cyc]  = cmd_ready;
    end
    if (rf_rd_en === 1'b1) rd_q.push_back('{cyc, int'(rf_rd_addr), RW'(0)});
    if (rf_wr_en === 1'b1) wr_q.push_back('{cyc, int'(rf_wr_addr), rf_wr_data});
    if (done === 1'b1) done_q.push_back(cyc);
    if (rf_rd_en === 1'b1 && rf_wr_en === 1'b1) clash++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] el(input logic [RW-1:0] row, input int j);
    return row[j*EW +: EW];
  endfunction

  // Reference: result matrix computed from a snapshot of the register file
  logic [RW-1:0] snap [2][NR];
  logic [RW-1:0] exp_rows [V];

  task automatic take_snap(input int s);
    for (int i = 0; i < NR; i++) snap[s][i] = mem[i];
  endtask

  task automatic model(input int s, input logic op, input int sa, input int sb);
    logic [EW-1:0] e;
    for (int r = 0; r < V; r++) begin
      exp_rows[r] = '0;
      for (int j = 0; j < V; j++) begin
        if (op == V_ADD) begin
          e = el(snap[s][(sa + r) % NR], j) + el(snap[s][(sb + r) % NR], j);
        end else begin
          e = '0;
          for (int k = 0; k < V; k++)
            e = e + el(snap[s][(sa + r) % NR], k) * el(snap[s][(sb + k) % NR], j);
        end
        exp_rows[r][j*EW +: EW] = e;
      end
    end
  endtask

  task automatic poke(input int a, input logic [RW-1:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [RW-1:0] mkrow(input int mode, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int j = 0; j < V; j++) begin
      case (mode)
        0: v[j*EW +: EW] = EW'(4 * r + j + 1);
        1: v[j*EW +: EW] = EW'(5);
        2: v[j*EW +: EW] = EW'(32'h10);
        3: v[j*EW +: EW] = EW'((j == r) ? 1 : 0);
        4: v[j*EW +: EW] = EW'((j == r) ? 2 : 0);
        default: v[j*EW +: EW] = '0;
      endcase
    end
    return v;
  endfunction

  // Called at a negedge; returns the cycle whose closing edge took the handshake
  task automatic issue(input logic op, input int sa, input int sb, input int dst, output int t);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_src_a = AW'(sa); cmd_src_b = AW'(sb); cmd_dst = AW'(dst);
    t = -1;
    for (int k = 0; k < 64; k++) begin
      if (cmd_ready === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk_i("issue_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_cmd(input int s, input int t, input logic op, input int sa, input int sb, input int dst);
    int nr, nw, nd, nb, nrd;
    nr = 0; nw = 0; nd = 0; nb = 0; nrd = 0;
    model(s, op, sa, sb);
    foreach (rd_q[i]) if (rd_q[i].cyc > t && rd_q[i].cyc <= t + 3*V + 3) begin
      if (nr < 2*V) begin
        chk_i("rd_addr", rd_q[i].addr, (nr < V) ? (sa + nr) % NR : (sb + nr - V) % NR);
        chk_i("rd_cycle", rd_q[i].cyc - t, nr + 1);
      end
      nr++;
    end
    chk_i("rd_count", nr, 2*V);
    foreach (wr_q[i]) if (wr_q[i].cyc > t && wr_q[i].cyc <= t + 3*V + 3) begin
      if (nw < V) begin
        chk_i("wr_addr", wr_q[i].addr, (dst + nw) % NR);
        chk_i("wr_cycle", wr_q[i].cyc - t, 2*V + 3 + nw);
        chk_v("wr_data", wr_q[i].data, exp_rows[nw]);
      end
      nw++;
    end
    chk_i("wr_count", nw, V);
    foreach (done_q[i]) if (done_q[i] > t && done_q[i] <= t + 3*V + 11) begin
      chk_i("done_cycle", done_q[i] - t, 3*V + 3);
      nd++;
    end
    chk_i("done_count", nd, 1);
    for (int c = t + 1; c <= t + 3*V + 3; c++) begin
      if (busy_h[c] === 1'b1) nb++;
      if (rdy_h[c] !== 1'b0) nrd++;
    end
    chk_i("busy_cycles", nb, 3*V + 3);
    chk_i("ready_while_busy", nrd, 0);
    chk_i("ready_after_done", (rdy_h[t + 3*V + 4] === 1'b1 && busy_h[t + 3*V + 4] === 1'b0) ? 1 : 0, 1);
  endtask

  task automatic run_cmd(input logic op, input int sa, input int sb, input int dst);
    int t;
    take_snap(0);
    issue(op, sa, sb, dst, t);
    cmd_valid = 1'b0;
    repeat (3*V + 6) @(negedge clk);
    check_cmd(0, t, op, sa, sb, dst);
  endtask

  task automatic chk_reset(input string p);
    logic [RW-1:0] orv;
    orv = '0;
    for (int i = 0; i < V; i++) orv = orv | valu_a[i] | valu_b[i];
    chk_i({p, "_cmd_ready"}, int'(cmd_ready), 1);
    chk_i({p, "_busy"}, int'(busy), 0);
    chk_i({p, "_done"}, int'(done), 0);
    chk_i({p, "_rd_en"}, int'(rf_rd_en), 0);
    chk_i({p, "_wr_en"}, int'(rf_wr_en), 0);
    chk_i({p, "_rd_addr"}, int'(rf_rd_addr), 0);
    chk_i({p, "_wr_addr"}, int'(rf_wr_addr), 0);
    chk_i({p, "_valu_op"}, int'(valu_op), int'(V_ADD));
    chk_v({p, "_wr_data"}, rf_wr_data, '0);
    chk_v({p, "_operands"}, orv, '0);
  endtask

  typedef struct {
    logic op; int sa; int sb; int dst; int am; int bm; int e00; int e33;
  } vec_t;
  vec_t tbl [5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   t, t1, nw, nd, nr;
    logic rop;
    int   rsa, rsb, rdst;

    tbl[0] = '{V_ADD,   0, 4,  8, 0,  2, 32'h11, 32'h20};
    tbl[1] = '{V_MMUL,  0, 4,  8, 0,  3, 1,      16};
    tbl[2] = '{V_MMUL,  0, 4,  8, 0,  4, 2,      32};
    tbl[3] = '{V_ADD,  30, 2, 31, 0,  2, 32'h11, 32'h20};
    tbl[4] = '{V_ADD,   0, 0,  0, 1, -1, 10,     10};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int n = 0; n < 5; n++) begin
      for (int r = 0; r < V; r++) begin
        poke((tbl[n].sa + r) % NR, mkrow(tbl[n].am, r));
        if (tbl[n].bm >= 0) poke((tbl[n].sb + r) % NR, mkrow(tbl[n].bm, r));
      end
      run_cmd(tbl[n].op, tbl[n].sa, tbl[n].sb, tbl[n].dst);
      chk_i($sformatf("tbl%0d_e00", n), int'(el(mem[tbl[n].dst], 0)), tbl[n].e00);
      chk_i($sformatf("tbl%0d_e33", n), int'(el(mem[(tbl[n].dst + 3) % NR], 3)), tbl[n].e33);
    end

    // Random contents and commands
    for (int i = 0; i < NR; i++)
      poke(i, {$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 8; n++) begin
      rop  = 1'($urandom_range(0, 1));
      rsa  = int'($urandom_range(0, NR - 1));
      rsb  = int'($urandom_range(0, NR - 1));
      rdst = int'($urandom_range(0, NR - 1));
      run_cmd(rop, rsa, rsb, rdst);
    end

    // cmd_valid held with changing fields while busy, then a second command offered during DONE
    take_snap(0);
    issue(V_MMUL, 3, 17, 9, t1);
    while (cyc < t1 + 3*V + 3) begin
      cmd_op    = 1'($urandom);
      cmd_src_a = AW'($urandom);
      cmd_src_b = AW'($urandom);
      cmd_dst   = AW'($urandom);
      @(negedge clk);
    end
    take_snap(1);
    cmd_op = V_ADD; cmd_src_a = AW'(20); cmd_src_b = AW'(9); cmd_dst = AW'(26);
    chk_i("ready_in_done", int'(cmd_ready), 0);
    @(negedge clk);
    chk_i("ready_in_idle", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_i("b2b_first_read", int'(rf_rd_en), 1);
    chk_i("b2b_first_addr", int'(rf_rd_addr), 20);
    repeat (3*V + 6) @(negedge clk);
    check_cmd(0, t1, V_MMUL, 3, 17, 9);
    check_cmd(1, t1 + 3*V + 4, V_ADD, 20, 9, 26);

    // Reset during writeback
    take_snap(0);
    issue(V_ADD, 8, 12, 20, t);
    cmd_valid = 1'b0;
    while (cyc < t + 12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    model(0, V_ADD, 8, 12);
    nw = 0; nd = 0; nr = 0;
    foreach (wr_q[i]) if (wr_q[i].cyc > t && wr_q[i].cyc <= t + 40) begin
      if (nw < 2) begin
        chk_i("midrst_wr_addr", wr_q[i].addr, 20 + nw);
        chk_v("midrst_wr_data", wr_q[i].data, exp_rows[nw]);
      end
      nw++;
    end
    foreach (done_q[i]) if (done_q[i] > t && done_q[i] <= t + 40) nd++;
    foreach (rd_q[i]) if (rd_q[i].cyc > t && rd_q[i].cyc <= t + 40) nr++;
    chk_i("midrst_wr_count", nw, 2);
    chk_i("midrst_done_count", nd, 0);
    chk_i("midrst_rd_count", nr, 2*V);
    chk_v("midrst_row_kept", mem[21], exp_rows[1]);
    run_cmd(V_ADD, 8, 12, 20);

    chk_i("strobe_separation", clash, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
